instr_fetch_queue: RTL and testbench

Instruction fetch front end sitting directly upstream of the single-cycle processor core. Generates sequential fetch addresses, issues one read at a time to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small FIFO. The core pops one instruction per cycle via valid/ready and redirects the fetch stream on taken branch/jump, which flushes the buffer and discards any in-flight response.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 88 ++++++++
 rtl/instr_fetch_queue.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_INC   = 4;
  localparam int unsigned RESET_PC = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Flushable FIFO of {pc, instr} entries with a registered head; valid rises
// the cycle after the first push into an empty queue.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   valid_o,
  output logic [W-1:0]           head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] remain;
  logic          valid_q, valid_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign do_push = push_i && !flush_i && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    remain   = count_q - CW'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      remain   = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = remain + CW'(do_push);
    end
  end

  // The new head comes straight from the write port when the queue would
  // otherwise be empty, since storage is only updated at the clock edge.
  always_comb begin
    valid_d = (count_d != '0);
    head_d  = '0;
    if (valid_d) begin
      if (remain == '0) head_d = push_data_i;
      else              head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with one outstanding memory read and a small
// prefetch FIFO. Define FETCH_STATS_EN to build the fetch/flush statistics.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [AW-1:0] start_pc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [31:0]   stat_fetched,
  output logic [15:0]   stat_flushed
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          mem_req_q;

  logic             fifo_push, fifo_pop, fifo_flush;
  logic [AW+DW-1:0] fifo_wdata, fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_valid;
  logic             credit;
  logic             redirect_live;

  // Requests are only issued from RUN, where nothing is outstanding, so the
  // credit test reduces to the FIFO occupancy alone.
  assign credit        = (fifo_count < FULL_CNT);
  assign redirect_live = redirect && (state_q != BOOT);
  assign fifo_wdata    = {fetch_pc_q, mem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    fifo_pop   = fifo_valid && instr_ready;
    case (state_q)
      BOOT: begin
        fetch_pc_d = start_pc;
        fifo_pop   = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        if (redirect) begin
          fifo_flush = 1'b1;
          fifo_pop   = 1'b0;
          fetch_pc_d = redirect_pc;
        end else if (credit) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          fifo_flush = 1'b1;
          fifo_pop   = 1'b0;
          fetch_pc_d = redirect_pc;
          state_d    = mem_ack ? RUN : DRAIN;
        end else if (mem_ack) begin
          fifo_push  = 1'b1;
          fetch_pc_d = fetch_pc_q + AW'(PC_INC);
          state_d    = RUN;
        end
      end
      DRAIN: begin
        if (redirect) begin
          fifo_flush = 1'b1;
          fifo_pop   = 1'b0;
          fetch_pc_d = redirect_pc;
        end
        if (mem_ack) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= BOOT;
      fetch_pc_q <= AW'(RESET_PC);
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= (state_d == WAIT);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (RESET),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .flush_i     (fifo_flush),
    .count_o     (fifo_count),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = fetch_pc_q;
  assign instr_valid = fifo_valid;
  assign instr       = fifo_head[DW-1:0];
  assign instr_pc    = fifo_head[AW+DW-1:DW];

`ifdef FETCH_STATS_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [31:0] fetched_q;
  logic [15:0] flushed_q;
  logic [15:0] flush_inc;

  // A redirect taken in WAIT always costs the in-flight response as well.
  assign flush_inc = 16'(fifo_count) + 16'(state_q == WAIT);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (fifo_push)     fetched_q <= fetched_q + 32'd1;
      if (redirect_live) flushed_q <= sat_add16(flushed_q, flush_inc);
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
`else
  assign stat_fetched = 32'd0;
  assign stat_flushed = 16'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic        CLK;
  logic        RESET;
  logic [31:0] start_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] stat_fetched;
  logic [15:0] stat_flushed;

  instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start_pc     (start_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stat_fetched (stat_fetched),
    .stat_flushed (stat_flushed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  ent_t        pop_log[$];
  logic [31:0] addr_log[$];

  int n_pass = 0;
  int n_chk  = 0;

  bit          m_boot, m_out, m_live;
  logic [31:0] nxt_pc;
  int          m_pushes;
  logic [31:0] m_fetched;
  int          m_flushed;
  bit          chk_en;

  int          lat;
  bit          rsp_busy;
  int          rsp_cnt;
  logic [31:0] rsp_addr;
  bit          rdy;
  bit          stray;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] addr_at(input int i);
    if (i < addr_log.size()) return addr_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    if (i < pop_log.size()) return pop_log[i].pc;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] data_at(input int i);
    if (i < pop_log.size()) return pop_log[i].data;
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    pop_log.delete();
    addr_log.delete();
    m_boot    = 1'b1;
    m_out     = 1'b0;
    m_live    = 1'b0;
    nxt_pc    = 32'h0;
    m_pushes  = 0;
    m_fetched = 32'h0;
    m_flushed = 0;
    rsp_busy  = 1'b0;
    rsp_cnt   = 0;
  endtask

  // Advance the reference model across the coming rising edge.
  task automatic model_step();
    ent_t e;
    if (m_boot) begin
      m_boot = 1'b0;
      nxt_pc = start_pc;
    end else begin
      if (mem_req && !m_out) begin
        chk("req_addr", 64'(mem_addr), 64'(nxt_pc));
        chk("req_credit", 64'(q.size() < DEPTH), 64'(1));
        addr_log.push_back(mem_addr);
        m_out  = 1'b1;
        m_live = 1'b1;
      end
      if (redirect) begin
        m_flushed = m_flushed + q.size() + int'(m_live);
        if (m_flushed > 65535) m_flushed = 65535;
        q.delete();
        if (mem_ack) m_out = 1'b0;
        m_live = 1'b0;
        nxt_pc = redirect_pc;
      end else begin
        if (q.size() != 0 && instr_ready) begin
          e = q.pop_front();
          pop_log.push_back(e);
        end
        if (mem_ack) begin
          if (m_live) begin
            e.pc   = nxt_pc;
            e.data = memfn(nxt_pc);
            q.push_back(e);
            nxt_pc    = nxt_pc + 32'd4;
            m_pushes  = m_pushes + 1;
            m_fetched = m_fetched + 32'd1;
          end
          m_out  = 1'b0;
          m_live = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input bit rd, input bit rd_on_ack, input logic [31:0] rpc);
    @(negedge CLK);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    if (stray) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'h0BAD_0BAD;
      stray     = 1'b0;
    end else begin
      if (!rsp_busy && mem_req) begin
        rsp_busy = 1'b1;
        rsp_addr = mem_addr;
        rsp_cnt  = lat;
      end
      if (rsp_busy) begin
        if (rsp_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = memfn(rsp_addr);
          rsp_busy  = 1'b0;
        end else begin
          rsp_cnt = rsp_cnt - 1;
        end
      end
    end
    redirect    = rd || (rd_on_ack && mem_ack);
    redirect_pc = rpc;
    instr_ready = rdy || (rd_on_ack && mem_ack);
    model_step();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] spc);
    RESET       = 1'b0;
    model_reset();
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    instr_ready = 1'b0;
    start_pc    = spc;
    stray       = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_instr_valid", 64'(instr_valid), 64'(0));
    chk("rst_instr", 64'(instr), 64'(0));
    chk("rst_instr_pc", 64'(instr_pc), 64'(0));
    chk("rst_stat_fetched", 64'(stat_fetched), 64'(0));
    RESET = 1'b1;
  endtask

  // Per-cycle comparison of the DUT against the model.
  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      chk("instr_valid", 64'(instr_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("instr_pc", 64'(instr_pc), 64'(q[0].pc));
        chk("instr", 64'(instr), 64'(q[0].data));
      end
      if (m_out && m_live) begin
        chk("mem_req_wait", 64'(mem_req), 64'(1));
        chk("mem_addr_wait", 64'(mem_addr), 64'(nxt_pc));
      end else if (m_out) begin
        chk("mem_req_drain", 64'(mem_req), 64'(0));
      end
`ifdef FETCH_STATS_EN
      chk("stat_fetched", 64'(stat_fetched), 64'(m_fetched));
      chk("stat_flushed", 64'(stat_flushed), 64'(m_flushed));
`else
      chk("stat_fetched", 64'(stat_fetched), 64'(0));
      chk("stat_flushed", 64'(stat_flushed), 64'(0));
`endif
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    chk_en = 1'b0;
    lat    = 0;
    rdy    = 1'b0;
    stray  = 1'b0;
    RESET  = 1'b0;
    start_pc = 32'h0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    @(posedge CLK);
    chk_en = 1'b1;

    // Boot and streaming with zero-latency memory
    do_reset(32'h0000_0100);
    rdy = 1'b1; lat = 0;
    repeat (14) cyc(1'b0, 1'b0, 32'h0);
    chk("boot_addr0", 64'(addr_at(0)), 64'h100);
    chk("boot_addr1", 64'(addr_at(1)), 64'h104);
    chk("boot_addr2", 64'(addr_at(2)), 64'h108);
    chk("boot_pc0", 64'(pc_at(0)), 64'h100);
    chk("boot_data0", 64'(data_at(0)), 64'hDEAD_0100);
    chk("boot_pc1", 64'(pc_at(1)), 64'h104);
    chk("boot_pc2", 64'(pc_at(2)), 64'h108);

    // Backpressure fills the queue, then resumes
    do_reset(32'h0000_0100);
    rdy = 1'b0; lat = 0;
    repeat (20) cyc(1'b0, 1'b0, 32'h0);
    chk("bp_pushes", 64'(m_pushes), 64'(4));
    chk("bp_mem_req", 64'(mem_req), 64'(0));
    chk("bp_valid", 64'(instr_valid), 64'(1));
    chk("bp_hold_pc", 64'(instr_pc), 64'h100);
    chk("bp_hold_instr", 64'(instr), 64'hDEAD_0100);
    rdy = 1'b1;
    repeat (14) cyc(1'b0, 1'b0, 32'h0);
    chk("bp_resume_addr", 64'(addr_at(4)), 64'h110);
    chk("bp_resume_pc", 64'(pc_at(4)), 64'h110);

    // Redirect while waiting on a slow response
    do_reset(32'h0000_0200);
    rdy = 1'b1; lat = 3;
    for (int i = 0; i < 20 && !m_out; i++) cyc(1'b0, 1'b0, 32'h0);
    chk("rw_req_seen", 64'(m_out), 64'(1));
    cyc(1'b1, 1'b0, 32'h0000_0400);
    chk("rw_drain_req", 64'(mem_req), 64'(0));
    repeat (30) cyc(1'b0, 1'b0, 32'h0);
    chk("rw_next_addr", 64'(addr_at(1)), 64'h400);
    chk("rw_first_pc", 64'(pc_at(0)), 64'h400);
    chk("rw_first_data", 64'(data_at(0)), 64'hDEAD_0400);

    // Redirect coinciding with an ack and a pop attempt
    do_reset(32'h0000_0300);
    rdy = 1'b0; lat = 1;
    for (int i = 0; i < 30 && m_pushes < 2; i++) cyc(1'b0, 1'b0, 32'h0);
    chk("ra_pushes", 64'(m_pushes), 64'(2));
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
        cyc(1'b0, 1'b1, 32'h0000_0500);
        hit = redirect;
      end
      chk("ra_redirect_hit", 64'(hit), 64'(1));
    end
    chk("ra_valid", 64'(instr_valid), 64'(0));
    chk("ra_no_pop", 64'(pop_log.size()), 64'(0));
    chk("ra_no_push", 64'(m_pushes), 64'(2));
    rdy = 1'b1;
    repeat (12) cyc(1'b0, 1'b0, 32'h0);
    chk("ra_next_addr", 64'(addr_at(3)), 64'h500);
    chk("ra_first_pc", 64'(pc_at(0)), 64'h500);

    // PC wraps past the top of the address space
    do_reset(32'hFFFF_FFFC);
    rdy = 1'b1; lat = 0;
    repeat (10) cyc(1'b0, 1'b0, 32'h0);
    chk("wrap_addr1", 64'(addr_at(1)), 64'h0);
    chk("wrap_pc0", 64'(pc_at(0)), 64'hFFFF_FFFC);
    chk("wrap_pc1", 64'(pc_at(1)), 64'h0);

    // Five fetches, two consumed, redirect flushes three
    do_reset(32'h0000_0800);
    lat = 0;
    for (int i = 0; i < 60 && m_pushes < 5; i++) begin
      rdy = (pop_log.size() < 2);
      cyc(1'b0, 1'b0, 32'h0);
    end
    rdy = 1'b0;
    chk("st_queued", 64'(q.size()), 64'(3));
    cyc(1'b1, 1'b0, 32'h0000_0A00);
`ifdef FETCH_STATS_EN
    chk("st_fetched", 64'(stat_fetched), 64'(5));
    chk("st_flushed", 64'(stat_flushed), 64'(3));
`else
    chk("st_fetched", 64'(stat_fetched), 64'(0));
    chk("st_flushed", 64'(stat_flushed), 64'(0));
`endif
    chk("st_valid", 64'(instr_valid), 64'(0));

    // Asynchronous reset during WAIT, then a stray ack in BOOT
    do_reset(32'h0000_0600);
    rdy = 1'b0; lat = 0;
    for (int i = 0; i < 30 && m_pushes < 2; i++) cyc(1'b0, 1'b0, 32'h0);
    lat = 5;
    for (int i = 0; i < 20 && !m_out; i++) cyc(1'b0, 1'b0, 32'h0);
    chk("ar_pre_req", 64'(mem_req), 64'(1));
    chk("ar_pre_valid", 64'(instr_valid), 64'(1));
    #1;
    RESET = 1'b0;
    model_reset();
    #1;
    chk("ar_mem_req", 64'(mem_req), 64'(0));
    chk("ar_mem_addr", 64'(mem_addr), 64'(0));
    chk("ar_valid", 64'(instr_valid), 64'(0));
    chk("ar_instr", 64'(instr), 64'(0));
    chk("ar_instr_pc", 64'(instr_pc), 64'(0));
    start_pc = 32'h0000_0700;
    mem_ack  = 1'b0;
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    stray = 1'b1; lat = 0; rdy = 1'b1;
    repeat (12) cyc(1'b0, 1'b0, 32'h0);
    chk("ar_boot_addr", 64'(addr_at(0)), 64'h700);
    chk("ar_boot_pc", 64'(pc_at(0)), 64'h700);
    chk("ar_boot_data", 64'(data_at(0)), 64'hDEAD_0700);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
